noc_out_port_arbiter: RTL and testbench
=======================================

// Module: noc_out_port_arbiter
// PURPOSE
//  Per-output-port wormhole arbiter for a 3x3 mesh router. Five inputs (Local, N, E, S, W) compete for one output link.
//  Round-robin grant on head flits; grant held until the tail flit passes. Output is one registered flit stage with valid/ready.
//  Instantiated once per output port in each router; the 9 PE local ports use 32-bit flits.
// PARAMETERS
//  NUM_PORTS    5   requesters; index 0 = Local, 1 = N, 2 = E, 3 = S, 4 = W
//  FLIT_W       32  flit width; type field is [FLIT_W-1:FLIT_W-2]
//  TIMEOUT_CYC  64  idle-owner cycles before forced release; used only with NOC_ARB_TIMEOUT_EN
// PORTS
//  clock      in   1                   system clock; all logic on posedge
//  reset      in   1                   synchronous, active-high
//  enable     in   1                   0 = freeze arbitration and input transfers
//  req_valid  in   NUM_PORTS           per-input flit valid
//  req_flit   in   NUM_PORTS*FLIT_W    per-input flit; port i at [i*FLIT_W +: FLIT_W]
//  req_ready  out  NUM_PORTS           per-input accept (combinational)
//  out_valid  out  1                   registered output flit valid
//  out_flit   out  FLIT_W              registered output flit
//  out_ready  in   1                   downstream accept
//  grant      out  NUM_PORTS           one-hot current owner; 0 when idle
//  locked     out  1                   1 while a packet owns the port
//  arb_timeout out 1                   1-cycle forced-release pulse (present only with NOC_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Flit type: 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 SINGLE.
//  Reset: out_valid=0, out_flit=0, grant=0, locked=0, arb_timeout=0, rr_ptr=NUM_PORTS-1, idle counter=0.
//  Reset mid-packet: lock dropped, buffered flit discarded; upstream resets in the same cycle.
//  FSM IDLE:
//   - enable=1 and any req_valid[i] with type HEAD or SINGLE -> pick first eligible i searching rr_ptr+1 .. rr_ptr+NUM_PORTS (mod).
//   - Next cycle: grant=onehot(i), locked=1, state LOCKED. The flit is not transferred in the picking cycle (1-cycle arbitration latency).
//   - BODY/TAIL at an input head while IDLE is ignored; it is never eligible.
//  FSM LOCKED:
//   - take = enable && req_valid[owner] && (!out_valid || out_ready).
//   - req_ready[i] = (i==owner) && enable && (!out_valid || out_ready) && state==LOCKED. All other req_ready = 0.
//   - On take: out_flit<=req_flit[owner], out_valid<=1. Max one flit per cycle; back-to-back flits at full rate.
//   - take of TAIL or SINGLE -> next cycle state IDLE, grant=0, locked=0, rr_ptr<=owner.
//     A new winner can be picked in that IDLE cycle, giving a 1-cycle bubble between packets.
//  Output stage: out_valid clears on out_ready && !take. Holds flit stable while !out_ready. Draining is independent of enable.
//  enable=0: no picks, req_ready=0, state/grant/rr_ptr held, idle counter held. The output register still drains.
//  Simultaneous requests: at most one grant per pick. Fairness: each requester waits at most NUM_PORTS-1 packets.
// CONFIGURATION
//  NOC_ARB_TIMEOUT_EN defined:
//   - In LOCKED with enable=1 and req_valid[owner]=0, the counter increments; any take clears it.
//   - Counter reaching TIMEOUT_CYC -> state IDLE, grant=0, locked=0, rr_ptr<=owner, arb_timeout=1 for one cycle, counter=0.
//  NOC_ARB_TIMEOUT_EN undefined: no counter, no arb_timeout port; the lock is held until TAIL/SINGLE indefinitely.
// STRUCTURE
//  noc_pkg: FLIT_W, NUM_PORTS, flit_type_e (BODY/HEAD/TAIL/SINGLE), port_idx_e (P_LOCAL,P_N,P_E,P_S,P_W), flit_type() function.
//  Sub-module noc_rr_pick: combinational round-robin picker (elig vector, rr_ptr -> onehot, any). Reused by the router crossbar.
//  Top: FSM, owner index register, output flit register, optional idle counter.
// TESTING
//  1. Reset with all inputs valid -> all outputs at reset values. First pick after reset is port 0 (rr_ptr=4).
//  2. Single SINGLE flit 32'hC000_00AA on port 2, out_ready=1 -> grant=5'b00100 at cycle 1, out_flit=32'hC000_00AA valid at cycle 2, IDLE at cycle 3.
//  3. Ports 1 and 3 send HEAD,BODY,TAIL at once -> port 1 packet out first, contiguous. Then 1 bubble, then port 3 packet. rr_ptr=3.
//  4. Mid-packet out_ready=0 for 5 cycles -> out_flit stable, req_ready[owner]=0, no flit lost or duplicated. Order preserved after release.
//  5. enable=0 for 3 cycles during LOCKED -> no take, state held. Buffered flit drains if out_ready=1. Transfer resumes on enable=1.
//  6. (NOC_ARB_TIMEOUT_EN, TIMEOUT_CYC=4) HEAD from port 4, then req_valid low -> arb_timeout pulse after 4 idle cycles, locked=0.
//     Port 0 HEAD then granted.
//  7. Assert reset during BODY transfer -> next cycle out_valid=0, grant=0. The next HEAD arbitrates normally.

Source files
------------

// File: rtl/noc_out_port_arbiter_pkg.sv
// Shared types and defaults for the mesh-router output-port arbiter and its
// round-robin picker: flit type encoding, port indices and the FSM state type.
package noc_out_port_arbiter_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int FLIT_W      = 32;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_N     = 3'd1,
    P_E     = 3'd2,
    P_S     = 3'd3,
    P_W     = 3'd4
  } port_idx_e;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } arb_state_e;

  // The caller passes the two type bits at the top of the flit.
  function automatic flit_type_e flit_type(input logic [1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// Request side (five upstream inputs) and output link of one router output
// port, plus the owner/lock status observed by the router.
interface noc_out_port_arbiter_if #(
  parameter int NUM_PORTS = noc_out_port_arbiter_pkg::NUM_PORTS,
  parameter int FLIT_W    = noc_out_port_arbiter_pkg::FLIT_W
) ();

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS*FLIT_W-1:0] req_flit;
  logic [NUM_PORTS-1:0]        req_ready;
  logic                        out_valid;
  logic [FLIT_W-1:0]           out_flit;
  logic                        out_ready;
  logic [NUM_PORTS-1:0]        grant;
  logic                        locked;

  // Environment side: upstream inputs and downstream link.
  modport master (
    output req_valid, req_flit, out_ready,
    input  req_ready, out_valid, out_flit, grant, locked
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_flit, out_ready,
    output req_ready, out_valid, out_flit, grant, locked
  );

endinterface

// File: rtl/noc_out_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after rr_ptr,
// wrapping modulo N. Shared with the router crossbar.
module noc_rr_pick
  import noc_out_port_arbiter_pkg::*;
#(
  parameter int N = NUM_PORTS
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         onehot,
  output logic                 any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    onehot = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && elig[(int'(rr_ptr) + k) % N]) begin
        any                             = 1'b1;
        onehot[(int'(rr_ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Wormhole output-port arbiter: round-robin on head flits, lock until tail,
// one registered output flit stage. Optional owner-idle release: NOC_ARB_TIMEOUT_EN.
module noc_out_port_arbiter #(
  parameter int NUM_PORTS   = noc_out_port_arbiter_pkg::NUM_PORTS,
  parameter int FLIT_W      = noc_out_port_arbiter_pkg::FLIT_W,
  parameter int TIMEOUT_CYC = noc_out_port_arbiter_pkg::TIMEOUT_CYC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  noc_out_port_arbiter_if.slave bus
`ifdef NOC_ARB_TIMEOUT_EN
  ,
  output logic                  arb_timeout
`endif
);

  import noc_out_port_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NUM_PORTS);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_e           state, state_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] elig, pick_onehot, ready, grant;
  logic                 pick_any;
  logic                 is_locked, space, take, last_take, expire;
  logic                 out_valid;
  logic [FLIT_W-1:0]    out_flit, owner_flit;
  flit_type_e           owner_type;

  // Only a packet opener (HEAD or SINGLE) may win; stray BODY/TAIL is ignored.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      case (flit_type(bus.req_flit[i*FLIT_W + FLIT_W - 2 +: 2]))
        HEAD, SINGLE: elig[i] = bus.req_valid[i];
        default:      elig[i] = 1'b0;
      endcase
    end
  end

  noc_rr_pick #(.N(NUM_PORTS)) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  assign is_locked  = (state == S_LOCKED);
  assign owner_flit = bus.req_flit[int'(owner)*FLIT_W +: FLIT_W];
  assign owner_type = flit_type(owner_flit[FLIT_W-1 -: 2]);
  assign space      = !out_valid || bus.out_ready;
  assign take       = is_locked && enable && bus.req_valid[owner] && space;
  assign last_take  = take && (owner_type == TAIL || owner_type == SINGLE);

  always_comb begin
    ready = '0;
    grant = '0;
    if (is_locked) begin
      grant[owner] = 1'b1;
      ready[owner] = enable && space;
    end
  end

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  // Counts only cycles where the owner could send but has nothing valid.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    expire       = 1'b0;
    if (!is_locked || take) begin
      idle_cnt_nxt = '0;
    end else if (enable && !bus.req_valid[owner]) begin
      if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        expire       = 1'b1;
        idle_cnt_nxt = '0;
      end else begin
        idle_cnt_nxt = idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      idle_cnt    <= idle_cnt_nxt;
      arb_timeout <= expire;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      S_IDLE: begin
        if (enable && pick_any) begin
          state_nxt = S_LOCKED;
          owner_nxt = pick_idx;
        end
      end
      S_LOCKED: begin
        if (last_take || expire) begin
          state_nxt  = S_IDLE;
          rr_ptr_nxt = owner;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Output stage drains on out_ready regardless of enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_flit  <= owner_flit;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.grant     = grant;
  assign bus.locked    = is_locked;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = out_flit;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Randomized and directed bench for noc_out_port_arbiter: cycle-level reference
// model of the arbitration rules plus a per-port in-order delivery scoreboard.
module tb_noc_out_port_arbiter;
  import noc_out_port_arbiter_pkg::*;

  localparam int NP = 5;
  localparam int FW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset, enable, ordy;
  logic [NP-1:0] rv;
  logic [FW-1:0] rf [NP];
`ifdef NOC_ARB_TIMEOUT_EN
  logic          arb_timeout;
`endif

  always #5 clock = ~clock;

  noc_out_port_arbiter_if #(.NUM_PORTS(NP), .FLIT_W(FW)) bus ();

  assign bus.req_valid = rv;
  assign bus.req_flit  = {rf[4], rf[3], rf[2], rf[1], rf[0]};
  assign bus.out_ready = ordy;

  noc_out_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW), .TIMEOUT_CYC(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus)
`ifdef NOC_ARB_TIMEOUT_EN
    ,
    .arb_timeout (arb_timeout)
`endif
  );

  // Reference model: owner < 0 means no packet owns the link.
  int          m_owner, m_rr, m_cnt;
  bit          m_ov, m_to;
  logic [31:0] m_of;

  logic [31:0] src_q [NP][$];
  logic [31:0] exp_q [NP][$];
  logic [31:0] want [$];
  logic [31:0] rx_log [$];
  int          gap_pct;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input int p, input int s);
    return {t, p[2:0], s[26:0]};
  endfunction

  task automatic push_flit(input int p, input logic [31:0] f);
    src_q[p].push_back(f);
    exp_q[p].push_back(f);
    want.push_back(f);
  endtask

  task automatic push_pkt(input int p, input int len, input int seq);
    if (len == 1) push_flit(p, mk(SINGLE, p, seq));
    else begin
      push_flit(p, mk(HEAD, p, seq));
      for (int k = 1; k < len - 1; k++) push_flit(p, mk(BODY, p, seq + k));
      push_flit(p, mk(TAIL, p, seq + len - 1));
    end
  endtask

  function automatic bit model_idle();
    int pending = 0;
    for (int i = 0; i < NP; i++) pending += src_q[i].size();
    return (pending == 0) && (m_owner < 0) && !m_ov;
  endfunction

  // One clock cycle: drive, check at negedge, advance model past the posedge.
  task automatic step();
    int          n_owner, n_rr, n_cnt, j;
    bit          n_ov, n_to, space, take, found;
    logic [31:0] n_of;
    logic [1:0]  t;
    logic [NP-1:0] e_rdy, e_grant;
    for (int i = 0; i < NP; i++) begin
      rv[i] = (src_q[i].size() > 0) && ($urandom_range(99) >= gap_pct);
      rf[i] = (src_q[i].size() > 0) ? src_q[i][0] : $urandom;
    end
    @(negedge clock);
    space   = !m_ov || ordy;
    e_rdy   = '0;
    e_grant = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_rdy[m_owner]   = enable && space;
    end
    check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check("grant",     32'(bus.grant),     32'(e_grant));
    check("locked",    32'(bus.locked),    32'(m_owner >= 0));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("out_flit",  bus.out_flit,       m_of);
`ifdef NOC_ARB_TIMEOUT_EN
    check("arb_timeout", 32'(arb_timeout), 32'(m_to));
`endif
    if (bus.out_valid && ordy) begin
      rx_log.push_back(bus.out_flit);
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (!found && exp_q[i].size() > 0 && exp_q[i][0] === bus.out_flit) begin
          void'(exp_q[i].pop_front());
          found = 1'b1;
        end
      end
      check("rx_in_order", 32'(found), 32'd1);
    end
    if (reset) begin
      n_owner = -1; n_rr = NP - 1; n_ov = 1'b0; n_of = '0; n_cnt = 0; n_to = 1'b0;
    end else begin
      take    = (m_owner >= 0) && enable && rv[m_owner] && space;
      n_ov    = take ? 1'b1 : (ordy ? 1'b0 : m_ov);
      n_of    = take ? rf[m_owner] : m_of;
      n_owner = m_owner; n_rr = m_rr; n_cnt = m_cnt; n_to = 1'b0;
      if (m_owner < 0) begin
        if (enable) begin
          for (int k = 1; k <= NP; k++) begin
            j = (m_rr + k) % NP;
            t = rf[j][31:30];
            if (n_owner < 0 && rv[j] && (t == HEAD || t == SINGLE)) n_owner = j;
          end
        end
      end else begin
        t = rf[m_owner][31:30];
        if (take && (t == TAIL || t == SINGLE)) begin
          n_owner = -1; n_rr = m_owner;
        end
`ifdef NOC_ARB_TIMEOUT_EN
        if (take) n_cnt = 0;
        else if (enable && !rv[m_owner]) begin
          n_cnt = m_cnt + 1;
          if (n_cnt == TO) begin
            n_cnt = 0; n_owner = -1; n_rr = m_owner; n_to = 1'b1;
          end
        end
`endif
      end
      if (take) void'(src_q[m_owner].pop_front());
    end
    @(posedge clock);
    #1;
    m_owner = n_owner; m_rr = n_rr; m_cnt = n_cnt; m_ov = n_ov; m_of = n_of; m_to = n_to;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while (!model_idle() && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(model_idle()), 32'd1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, 32'(rx_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < rx_log.size(); i++) check(tag, rx_log[i], want[i]);
  endtask

  task automatic start_case();
    want.delete();
    rx_log.delete();
  endtask

  initial begin
    int pulses;
    reset = 1'b1; enable = 1'b1; ordy = 1'b1; gap_pct = 0;
    for (int i = 0; i < NP; i++) begin rv[i] = 1'b0; rf[i] = '0; end

    // Reset with every input presenting a SINGLE; first pick must be port 0.
    start_case();
    for (int i = 0; i < NP; i++) push_pkt(i, 1, 100 + i);
    repeat (2) @(posedge clock);
    #1;
    m_owner = -1; m_rr = NP - 1; m_cnt = 0; m_ov = 1'b0; m_of = '0; m_to = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("t1_first_grant", 32'(bus.grant), 32'b00001);
    run_until_idle(100);
    check_rx("t1_order");

    // Lone SINGLE on port 2: grant, output and idle timing.
    start_case();
    push_flit(2, 32'hC000_00AA);
    step();
    check("t2_grant_c1", 32'(bus.grant), 32'b00100);
    step();
    check("t2_valid_c2", 32'(bus.out_valid), 32'd1);
    check("t2_flit_c2", bus.out_flit, 32'hC000_00AA);
    step();
    check("t2_idle_c3", 32'(bus.locked), 32'd0);

    // Concurrent packets on ports 1 and 3 after reset: port 1 wins, then port 3.
    reset = 1'b1; step(); reset = 1'b0;
    start_case();
    push_pkt(1, 3, 10);
    push_pkt(3, 3, 20);
    run_until_idle(100);
    check_rx("t3_order");
    // Pointer now at 3, so port 4 must beat port 0.
    start_case();
    push_pkt(4, 1, 30);
    push_pkt(0, 1, 40);
    run_until_idle(100);
    check_rx("t3_wrap");

    // Downstream stall for 5 cycles mid-packet.
    start_case();
    push_pkt(0, 6, 50);
    repeat (3) step();
    ordy = 1'b0;
    repeat (5) step();
    ordy = 1'b1;
    run_until_idle(100);
    check_rx("t4_stall");

    // enable low for 3 cycles while locked; the output still drains.
    start_case();
    push_pkt(3, 5, 60);
    repeat (2) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    run_until_idle(100);
    check_rx("t5_enable");

`ifdef NOC_ARB_TIMEOUT_EN
    // Owner goes silent after its HEAD: forced release, then port 0 proceeds.
    start_case();
    push_flit(4, mk(HEAD, 4, 70));
    pulses = 0;
    repeat (8) begin
      step();
      if (arb_timeout) pulses++;
    end
    check("t6_pulses", 32'(pulses), 32'd1);
    push_pkt(0, 2, 80);
    run_until_idle(100);
    check_rx("t6_after");
`endif

    // Reset during a BODY transfer; upstream drops the rest of its packet.
    start_case();
    push_pkt(2, 5, 90);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    src_q[2].delete();
    exp_q[2].delete();
    check("t7_valid_cleared", 32'(bus.out_valid), 32'd0);
    check("t7_grant_cleared", 32'(bus.grant), 32'd0);
    start_case();
    push_pkt(1, 2, 95);
    run_until_idle(100);
    check_rx("t7_after");

    // A BODY flit at an input while idle never wins.
    src_q[3].push_back(mk(BODY, 3, 99));
    repeat (4) step();
    check("t8_body_ignored", 32'(bus.locked), 32'd0);
    src_q[3].delete();

    // Random traffic with random back-pressure and enable.
    start_case();
`ifdef NOC_ARB_TIMEOUT_EN
    gap_pct = 0;
`else
    gap_pct = 30;
`endif
    for (int p = 0; p < NP; p++)
      for (int n = 0; n < 15; n++) push_pkt(p, $urandom_range(1, 4), 1000 + p * 200 + n * 10);
    repeat (1500) begin
      ordy   = ($urandom_range(99) < 70);
      enable = ($urandom_range(99) < 90);
      step();
    end
    ordy = 1'b1; enable = 1'b1; gap_pct = 0;
    run_until_idle(3000);
    check("rand_delivered", 32'(rx_log.size()), 32'(want.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
